// File: rtl/audio_dac_if.sv
// Byte-level valid/ready stream carrying framed DAC writes to the I2C controller.
interface audio_dac_if;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_first;
  logic       tx_last;

  modport master (output tx_valid, tx_data, tx_first, tx_last, input tx_ready);
  modport slave  (input tx_valid, tx_data, tx_first, tx_last, output tx_ready);
endinterface

// File: rtl/audio_dac_streamer.sv
// Paced multi-channel mixer that frames each saturated DAC code as an
// MCP4725-style I2C write and streams the bytes over a valid/ready link.
module audio_dac_streamer #(
  parameter int          NUM_CHANNELS = 4,
  parameter int          IN_BITS      = 12,
  parameter int          DAC_BITS     = 12,
  parameter int          SHIFT        = 0,
  parameter int          CLK_HZ       = 12_000_000,
  parameter int          SAMPLE_HZ    = 8_000,
  parameter logic [6:0]  DAC_ADDR     = 7'h62
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             ena,
  input  logic                             mode,
  input  logic [NUM_CHANNELS*IN_BITS-1:0]  ch_data,
  input  logic [NUM_CHANNELS-1:0]          ch_mute,
  output logic [6:0]                       i2c_addr,
  audio_dac_if.master                      tx,
  output logic                             busy,
  output logic [DAC_BITS-1:0]              sample_out,
  output logic                             clip,
  output logic [15:0]                      underrun_count
);

  localparam int          TICKS = CLK_HZ / SAMPLE_HZ;
  localparam int          CNT_W = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam int          SUM_W = IN_BITS + $clog2(NUM_CHANNELS);
  localparam int unsigned MAXC  = (2 ** DAC_BITS) - 1;

  typedef enum logic [1:0] {S_IDLE, S_MIX, S_SEND} state_t;

  state_t                            state_q, state_d;
  logic [CNT_W-1:0]                  cnt_q;
  logic                              tick_q, tick;
  logic [1:0]                        idx_q, idx_d, last_idx;
  logic                              mode_q;
  logic [NUM_CHANNELS*IN_BITS-1:0]   data_q;
  logic [NUM_CHANNELS-1:0]           mute_q;
  logic [DAC_BITS-1:0]               sample_q;
  logic                              clip_q;
  logic [15:0]                       under_q;
  logic [SUM_W-1:0]                  sum_w, shifted_w;
  logic [DAC_BITS:0]                 sat_w;
  logic [11:0]                       d12;
  logic [7:0]                        byte_w;

  // Returns {clip, code}: codes above full scale pin to all-ones.
  function automatic logic [DAC_BITS:0] saturate(input logic [SUM_W-1:0] v);
    if (32'(v) > MAXC) return {1'b1, {DAC_BITS{1'b1}}};
    return {1'b0, DAC_BITS'(v)};
  endfunction

  // Sample-rate pacing: tick is registered so it lands TICKS cycles after ena rises.
  always_ff @(posedge clk) begin
    if (rst || !ena) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= (cnt_q == CNT_W'(TICKS - 1));
      cnt_q  <= (cnt_q == CNT_W'(TICKS - 1)) ? '0 : cnt_q + 1'b1;
    end
  end

  assign tick = tick_q & ena;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      mode_q  <= 1'b0;
      clip_q  <= 1'b0;
      under_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (state_q == S_IDLE && tick) mode_q <= mode;
      if (state_q == S_MIX) clip_q <= sat_w[DAC_BITS];
      else if (state_d == S_IDLE) clip_q <= 1'b0;
      if (tick && state_q != S_IDLE && under_q != 16'hFFFF) under_q <= under_q + 16'd1;
    end
  end

  // Capture stage: channel samples are frozen at the tick for the whole frame.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && tick) begin
      data_q <= ch_data;
      mute_q <= ch_mute;
    end
  end

  always_comb begin
    sum_w = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (!mute_q[k]) sum_w = sum_w + SUM_W'(data_q[k*IN_BITS +: IN_BITS]);
    end
  end

  assign shifted_w = sum_w >> SHIFT;
  assign sat_w     = saturate(shifted_w);

  // Mix stage: sample_out is the only data register cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) sample_q <= '0;
    else if (state_q == S_MIX) sample_q <= sat_w[DAC_BITS-1:0];
  end

  assign last_idx = mode_q ? 2'd2 : 2'd1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: if (tick) state_d = S_MIX;
      S_MIX: begin
        idx_d   = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (tx.tx_ready) begin
          if (idx_q == last_idx) state_d = S_IDLE;
          else idx_d = idx_q + 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Send stage: frame bytes derive from the left-aligned 12-bit code.
  assign d12 = 12'(sample_q) << (12 - DAC_BITS);

  always_comb begin
    byte_w = 8'h00;
    if (!mode_q) begin
      byte_w = (idx_q == 2'd0) ? {4'b0000, d12[11:8]} : d12[7:0];
    end else begin
      case (idx_q)
        2'd0:    byte_w = 8'h40;
        2'd1:    byte_w = d12[11:4];
        default: byte_w = {d12[3:0], 4'h0};
      endcase
    end
  end

  assign tx.tx_valid    = (state_q == S_SEND);
  assign tx.tx_data     = tx.tx_valid ? byte_w : 8'h00;
  assign tx.tx_first    = tx.tx_valid && (idx_q == 2'd0);
  assign tx.tx_last     = tx.tx_valid && (idx_q == last_idx);
  assign busy           = (state_q != S_IDLE);
  assign sample_out     = sample_q;
  assign clip           = clip_q;
  assign underrun_count = under_q;
  assign i2c_addr       = DAC_ADDR;

endmodule

// File: tb/tb_audio_dac_streamer.sv
// Directed-vector bench for audio_dac_streamer: default build plus a reduced
// 8-bit, shifted, single-channel build with a short sample period.
module tb_audio_dac_streamer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ena, mode;
  logic [47:0] ch_data;
  logic [3:0]  ch_mute;
  logic [6:0]  i2c_addr;
  logic        busy, clip;
  logic [11:0] sample_out;
  logic [15:0] underrun_count;
  audio_dac_if bus();

  audio_dac_streamer u_dut (
    .clk(clk), .rst(rst), .ena(ena), .mode(mode),
    .ch_data(ch_data), .ch_mute(ch_mute), .i2c_addr(i2c_addr),
    .tx(bus), .busy(busy), .sample_out(sample_out), .clip(clip),
    .underrun_count(underrun_count)
  );

  logic        ena2, mode2;
  logic [11:0] ch2;
  logic [0:0]  mute2;
  logic [6:0]  addr2;
  logic        busy2, clip2;
  logic [7:0]  sample2;
  logic [15:0] under2;
  audio_dac_if bus2();

  audio_dac_streamer #(
    .NUM_CHANNELS(1), .IN_BITS(12), .DAC_BITS(8), .SHIFT(4),
    .CLK_HZ(16), .SAMPLE_HZ(1)
  ) u_small (
    .clk(clk), .rst(rst), .ena(ena2), .mode(mode2),
    .ch_data(ch2), .ch_mute(mute2), .i2c_addr(addr2),
    .tx(bus2), .busy(busy2), .sample_out(sample2), .clip(clip2),
    .underrun_count(under2)
  );

  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.tx_valid && n < limit);
    if (!bus.tx_valid) chk("valid_timeout", bus.tx_valid, 1);
  endtask

  task automatic get_frame(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input int nb);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < nb; i++) begin
      logic [7:0] e;
      e = (i == 0) ? b0 : (i == 1) ? b1 : b2;
      chk($sformatf("%s_vld%0d", tag, i),   bus.tx_valid, 1);
      chk($sformatf("%s_data%0d", tag, i),  bus.tx_data, e);
      chk($sformatf("%s_first%0d", tag, i), bus.tx_first, (i == 0));
      chk($sformatf("%s_last%0d", tag, i),  bus.tx_last, (i == nb - 1));
      @(posedge clk); #1;
    end
    chk($sformatf("%s_done", tag), bus.tx_valid, 0);
    chk($sformatf("%s_idle", tag), busy, 0);
  endtask

  localparam logic [47:0] CH_BASE = {12'h050, 12'h300, 12'h200, 12'h100};

  initial begin
    int n, bad;
    rst = 1'b1; ena = 1'b0; mode = 1'b0; ch_data = CH_BASE; ch_mute = 4'b0000;
    bus.tx_ready = 1'b1;
    ena2 = 1'b0; mode2 = 1'b0; ch2 = 12'hABC; mute2 = 1'b0; bus2.tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", bus.tx_valid, 0);
    chk("rst_first", bus.tx_first, 0);
    chk("rst_last", bus.tx_last, 0);
    chk("rst_data", bus.tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_clip", clip, 0);
    chk("rst_sample", sample_out, 0);
    chk("rst_under", underrun_count, 0);
    chk("i2c_addr", i2c_addr, 7'h62);

    rst = 1'b0; ena = 1'b1;
    wait_valid(4000, n);
    chk("lat_first", n, 1502);
    chk("m0_sample", sample_out, 12'h650);
    chk("m0_clip", clip, 0);
    chk("m0_busy", busy, 1);
    get_frame("m0", 8'h06, 8'h50, 8'h00, 2);

    mode = 1'b1;
    wait_valid(4000, n);
    chk("m1_sample", sample_out, 12'h650);
    get_frame("m1", 8'h40, 8'h65, 8'h00, 3);

    mode = 1'b0; ch_data = {4{12'hFFF}};
    wait_valid(4000, n);
    chk("sat_sample", sample_out, 12'hFFF);
    chk("sat_clip", clip, 1);
    get_frame("sat", 8'h0F, 8'hFF, 8'h00, 2);

    ch_mute = 4'b1010; ch_data = {12'hFFF, 12'h020, 12'hFFF, 12'h010};
    wait_valid(4000, n);
    chk("mute_sample", sample_out, 12'h030);
    chk("mute_clip", clip, 0);
    mode = 1'b1; ch_data = '0;
    get_frame("mute", 8'h00, 8'h30, 8'h00, 2);
    mode = 1'b0; ch_mute = 4'b0000; ch_data = CH_BASE;

    bus.tx_ready = 1'b0;
    wait_valid(4000, n);
    bad = 0;
    repeat (3200) begin
      @(posedge clk); #1;
      if (!bus.tx_valid || bus.tx_data !== 8'h06 || !bus.tx_first) bad++;
    end
    chk("stall_hold", bad, 0);
    chk("stall_data", bus.tx_data, 8'h06);
    chk("stall_under", underrun_count, 2);
    get_frame("stall", 8'h06, 8'h50, 8'h00, 2);

    bus.tx_ready = 1'b0;
    wait_valid(4000, n);
    bus.tx_ready = 1'b1;
    @(posedge clk); #1;
    bus.tx_ready = 1'b0;
    chk("rst_b1_data", bus.tx_data, 8'h50);
    chk("rst_b1_first", bus.tx_first, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_valid", bus.tx_valid, 0);
    chk("midrst_under", underrun_count, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_sample", sample_out, 0);
    rst = 1'b0;
    wait_valid(4000, n);
    chk("lat_rst", n, 1502);
    ena = 1'b0;
    get_frame("post_rst", 8'h06, 8'h50, 8'h00, 2);
    bad = 0;
    repeat (2000) begin
      @(posedge clk); #1;
      if (bus.tx_valid || busy) bad++;
    end
    chk("ena_off_quiet", bad, 0);

    ena2 = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus2.tx_valid && n < 100);
    chk("small_lat", n, 18);
    chk("small_sample", sample2, 8'hAB);
    chk("small_clip", clip2, 0);
    chk("small_b0", bus2.tx_data, 8'h0A);
    chk("small_b0_first", bus2.tx_first, 1);
    @(posedge clk); #1;
    chk("small_b1", bus2.tx_data, 8'hB0);
    chk("small_b1_last", bus2.tx_last, 1);
    @(posedge clk); #1;
    chk("small_done", bus2.tx_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
